// File: rtl/pipe_skid_reg_pkg.sv
// rtl/pipe_skid_reg_pkg.sv - shared pipeline constants and occupancy state encoding
package pipe_skid_reg_pkg;

  localparam int BIT_WIDTH = 8;

  // State value doubles as the occupancy count.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } skid_state_t;

endpackage

// File: rtl/pipe_skid_reg_if.sv
// rtl/pipe_skid_reg_if.sv - producer/consumer valid-ready handshake bundle
import pipe_skid_reg_pkg::*;

interface pipe_skid_reg_if #(
  parameter int W = BIT_WIDTH
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );
endinterface

// File: rtl/pipe_skid_reg_dffre.sv
// rtl/pipe_skid_reg_dffre.sv - W-bit register with async active-low reset and load enable
module pipe_skid_reg_dffre #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q <= '0;
    end else if (i_en) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/pipe_skid_reg.sv
// rtl/pipe_skid_reg.sv - two-entry skid buffer with registered in_ready and full throughput
module pipe_skid_reg
  import pipe_skid_reg_pkg::*;
#(
  parameter int N = BIT_WIDTH
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_flush,
  output logic [1:0]      o_count,
  pipe_skid_reg_if.slave  bus
);

  skid_state_t r_state;
  skid_state_t w_state_nxt;
  logic        r_alive;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_main_en;
  logic        w_skid_en;
  logic [N-1:0] w_main_d;
  logic [N-1:0] w_main_q;
  logic [N-1:0] w_skid_q;

  // Holds in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_alive <= 1'b0;
      r_state <= ST_EMPTY;
    end else begin
      r_alive <= 1'b1;
      r_state <= w_state_nxt;
    end
  end

  assign bus.in_ready  = r_alive & (r_state != ST_FULL) & ~i_flush & rst_n;
  assign bus.out_valid = (r_state != ST_EMPTY);
  assign bus.out_data  = w_main_q;
  assign o_count       = r_state;

  assign w_in_fire  = bus.in_valid & bus.in_ready;
  assign w_out_fire = bus.out_valid & bus.out_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_main_en   = 1'b0;
    w_skid_en   = 1'b0;
    w_main_d    = bus.in_data;
    if (i_flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      unique case (r_state)
        ST_EMPTY: begin
          if (w_in_fire) begin
            w_state_nxt = ST_ONE;
            w_main_en   = 1'b1;
          end
        end
        ST_ONE: begin
          if (w_in_fire && w_out_fire) begin
            w_main_en = 1'b1;
          end else if (w_in_fire) begin
            w_state_nxt = ST_FULL;
            w_skid_en   = 1'b1;
          end else if (w_out_fire) begin
            w_state_nxt = ST_EMPTY;
          end
        end
        ST_FULL: begin
          if (w_out_fire) begin
            w_state_nxt = ST_ONE;
            w_main_en   = 1'b1;
            w_main_d    = w_skid_q;
          end
        end
        default: begin
          w_state_nxt = ST_EMPTY;
        end
      endcase
    end
  end

  pipe_skid_reg_dffre #(.W(N)) u_main (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_main_en),
    .i_d   (w_main_d),
    .o_q   (w_main_q)
  );

  pipe_skid_reg_dffre #(.W(N)) u_skid (
    .clk   (clk),
    .rst_n (rst_n),
    .i_en  (w_skid_en),
    .i_d   (bus.in_data),
    .o_q   (w_skid_q)
  );

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb/tb_pipe_skid_reg.sv - vector table, corner sequences and scoreboarded random traffic
module tb_pipe_skid_reg;
  import pipe_skid_reg_pkg::*;

  typedef struct {
    logic       iv;
    logic [7:0] id;
    logic       ordy;
    logic       fl;
    logic       ov;
    logic [7:0] od;
    logic [1:0] cnt;
    logic       ir;
  } vec_t;

  logic       clk;
  logic       rst_n;
  logic       flush;
  logic [1:0] count;
  logic       post_rst;
  int         n_cmp;
  int         n_fail;
  logic [7:0] sb[$];
  logic [7:0] exp_d;
  vec_t       vecs[$];

  pipe_skid_reg_if #(.W(8)) bus ();

  pipe_skid_reg #(.N(8)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (flush),
    .o_count (count),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) post_rst <= 1'b0;
    else        post_rst <= 1'b1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic iv, input logic [7:0] id, input logic ordy,
                              input logic fl, input logic ov, input logic [7:0] od,
                              input logic [1:0] cnt, input logic ir);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy; v.fl = fl;
    v.ov = ov; v.od = od; v.cnt = cnt; v.ir = ir;
    return v;
  endfunction

  // Scoreboard: push on accepted input, pop and compare on consumer transfer.
  always @(posedge clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL sb_underflow: got word %0h expected none at %0t", bus.out_data, $time);
        end else begin
          exp_d = sb.pop_front();
          check("sb_data", {24'd0, bus.out_data}, {24'd0, exp_d});
        end
      end
      if (flush) sb.delete();
      else if (bus.in_valid && bus.in_ready) sb.push_back(bus.in_data);
    end
  end

  always @(negedge rst_n) sb.delete();

  task automatic drive(input logic iv, input logic [7:0] id, input logic ordy, input logic fl);
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    flush         = fl;
  endtask

  initial begin
    n_cmp = 0;
    n_fail = 0;
    rst_n = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);

    // 1: single word; 2: stream; 3: stall; 4: flush from FULL
    vecs.push_back(mk(1, 8'hA5, 1, 0, 0, 8'h00, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'hA5, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'hA5, 0, 1));
    for (int i = 1; i <= 16; i++) begin
      vecs.push_back(mk(1, 8'(i), 1, 0, (i > 1), (i == 1) ? 8'hA5 : 8'(i - 1),
                        (i > 1) ? 2'd1 : 2'd0, 1));
    end
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h10, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h10, 0, 1));
    vecs.push_back(mk(1, 8'h11, 0, 0, 0, 8'h10, 0, 1));
    vecs.push_back(mk(1, 8'h22, 0, 0, 1, 8'h11, 1, 1));
    vecs.push_back(mk(1, 8'h33, 0, 0, 1, 8'h11, 2, 0));
    vecs.push_back(mk(1, 8'h33, 0, 0, 1, 8'h11, 2, 0));
    vecs.push_back(mk(1, 8'h33, 1, 0, 1, 8'h11, 2, 0));
    vecs.push_back(mk(1, 8'h33, 1, 0, 1, 8'h22, 1, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 1, 8'h33, 1, 1));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h33, 0, 1));
    vecs.push_back(mk(1, 8'h44, 0, 0, 0, 8'h33, 0, 1));
    vecs.push_back(mk(1, 8'h55, 0, 0, 1, 8'h44, 1, 1));
    vecs.push_back(mk(1, 8'h66, 0, 1, 1, 8'h44, 2, 0));
    vecs.push_back(mk(0, 8'h00, 0, 0, 0, 8'h44, 0, 1));
    vecs.push_back(mk(0, 8'h00, 1, 0, 0, 8'h44, 0, 1));

    repeat (2) @(negedge clk);
    check("rst_out_valid", {31'd0, bus.out_valid}, 0);
    check("rst_out_data", {24'd0, bus.out_data}, 0);
    check("rst_count", {30'd0, count}, 0);
    check("rst_in_ready", {31'd0, bus.in_ready}, 0);
    rst_n = 1'b1;
    #1 check("rel_in_ready_pre_edge", {31'd0, bus.in_ready}, 0);

    foreach (vecs[k]) begin
      @(negedge clk);
      drive(vecs[k].iv, vecs[k].id, vecs[k].ordy, vecs[k].fl);
      #1;
      check($sformatf("v%0d_out_valid", k), {31'd0, bus.out_valid}, {31'd0, vecs[k].ov});
      check($sformatf("v%0d_out_data", k), {24'd0, bus.out_data}, {24'd0, vecs[k].od});
      check($sformatf("v%0d_count", k), {30'd0, count}, {30'd0, vecs[k].cnt});
      check($sformatf("v%0d_in_ready", k), {31'd0, bus.in_ready}, {31'd0, vecs[k].ir});
    end

    // 5: asynchronous reset while FULL
    @(negedge clk) drive(1, 8'h88, 0, 0);
    @(negedge clk) drive(1, 8'h99, 0, 0);
    @(negedge clk) drive(0, 8'h00, 0, 0);
    #1 check("pre_rst_count", {30'd0, count}, 2);
    #1 rst_n = 1'b0;
    #1;
    check("arst_out_valid", {31'd0, bus.out_valid}, 0);
    check("arst_count", {30'd0, count}, 0);
    check("arst_in_ready", {31'd0, bus.in_ready}, 0);
    check("arst_out_data", {24'd0, bus.out_data}, 0);
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) drive(1, 8'h77, 1, 0);
    #1 check("post_rst_in_ready", {31'd0, bus.in_ready}, 1);
    @(negedge clk) drive(0, 8'h00, 1, 0);
    #1;
    check("post_rst_out_valid", {31'd0, bus.out_valid}, 1);
    check("post_rst_out_data", {24'd0, bus.out_data}, 8'h77);
    check("post_rst_count", {30'd0, count}, 1);

    // 6: random traffic against the scoreboard
    for (int c = 0; c < 10000; c++) begin
      @(negedge clk);
      drive(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
            1'($urandom_range(0, 1)), ($urandom_range(0, 63) == 0));
      #1;
      if (!flush && post_rst) begin
        check("rnd_in_ready", {31'd0, bus.in_ready}, {31'd0, (count != 2'd2)});
      end
      check("rnd_count", {30'd0, count}, sb.size());
    end
    @(negedge clk) drive(0, 8'h00, 1, 0);
    repeat (4) @(negedge clk);
    check("drain_empty", sb.size(), 0);
    check("drain_out_valid", {31'd0, bus.out_valid}, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/pipe_skid_reg.md
Name: pipe_skid_reg

Overview:
- Two-entry elastic pipeline register (skid buffer) with valid/ready handshakes on both sides.
- Input side: a producer stage offers data. Output side: a consumer stage takes data when ready.
- Full throughput (one word per cycle) with registered in_ready, so no combinational ready path crosses stages.
- Used between CPU pipeline stages where the downstream stage can stall.

Parameters:
n, BIT_WIDTH, data width in bits of in_data/out_data

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous discard of all held data
in_valid  input  1  producer offers in_data this cycle
in_ready  output  1  block can accept a word this cycle
in_data  input  n  producer data
out_valid  output  1  out_data holds a valid word
out_ready  input  1  consumer takes out_data this cycle
out_data  output  n  oldest held word
count  output  2  occupancy, 0..2

Behaviour:
- Reset (rst_n low, asynchronous):
  - state EMPTY; main and skid registers = 0.
  - out_valid = 0, out_data = 0, count = 0, in_ready = 0 while rst_n is low.
  - in_ready = 1 from the first posedge after rst_n deasserts.
- Handshakes:
  - in_fire = in_valid & in_ready.
  - out_fire = out_valid & out_ready.
- Storage:
  - Main register drives out_data.
  - Skid register holds the second word.
- Outputs:
  - in_ready = (state != FULL) & !flush & rst_n.
  - out_valid = (state != EMPTY).
  - count = 0 / 1 / 2 for EMPTY / ONE / FULL.
- Latency: a word accepted at edge k appears on out_data/out_valid after edge k (1 cycle).
- Ordering: strict FIFO order; no word is dropped or duplicated.
- State transitions (evaluated at posedge, flush low):
  - EMPTY: in_fire -> ONE, main <= in_data. Otherwise stay.
  - ONE, in_fire & out_fire -> ONE, main <= in_data.
  - ONE, in_fire & !out_fire -> FULL, skid <= in_data.
  - ONE, !in_fire & out_fire -> EMPTY.
  - ONE, neither fires -> hold.
  - FULL (in_ready = 0): out_fire -> ONE, main <= skid. Otherwise hold.
- Flush (highest priority below reset):
  - At posedge with flush = 1: state -> EMPTY, count -> 0.
  - in_ready is low while flush is high, so no input is accepted that cycle.
  - An out_fire in the same cycle is still a valid consumer transfer.
  - Data registers need not be cleared.
- Stall holding:
  - While out_valid = 1 and out_ready = 0, out_data stays stable.
  - out_valid does not drop without out_fire or flush.
- Data capture: in_data is ignored when in_fire = 0; registers change only on the listed events.
- Reset mid-operation: all held words are discarded immediately and asynchronously.
- No combinational path from out_ready to in_ready, or from in_valid to out_valid.

Decomposition:
- BIT_WIDTH stays in the shared constants header.
- State encoding (EMPTY=2'd0, ONE=2'd1, FULL=2'd2) goes in a shared pipeline package so other stage wrappers reuse it; count is the state value.
- One natural sub-module: _dffre, an n-bit register with asynchronous active-low reset and enable. Instantiate it twice (main, skid).
- Next-state logic stays in this block.

Test Plan:
1. Reset, then in_valid=1 with in_data=8'hA5 for one cycle, out_ready=1 -> out_valid=1, out_data=8'hA5 one cycle later; count 0->1->0.
2. Streaming 8'h01..8'h10 with in_valid=1 and out_ready=1 every cycle -> one word out per cycle, in order, in_ready stays 1, count stays 1.
3. out_ready=0 while pushing 8'h11, 8'h22, 8'h33 -> first two accepted, count=2, in_ready=0, 8'h33 held by producer. Release out_ready -> outputs 11, 22, 33 in order; out_data stable during the stall.
4. FULL with words 8'h44/8'h55, assert flush one cycle with in_valid=1 and in_data=8'h66 -> in_ready=0 that cycle, then count=0, out_valid=0; 8'h66 never appears.
5. Async reset: drop rst_n mid-cycle while FULL -> out_valid, count, in_ready go to 0 immediately without a clock edge. After release, a new push of 8'h77 emerges cleanly.
6. Random valid/ready (about 10k cycles) against a scoreboard queue -> no loss, duplication or reordering. Assert in_ready == (count != 2) whenever flush=0 and rst_n=1.
